// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage: RV32I/RV64I instruction decode pipeline stage.
// An output register (OR) holds the decoded bundle. A single skid entry (SK)
// holds a raw instruction that was accepted while OR was stalled. Together
// they form a 2-entry buffer, so the stage absorbs back-pressure without
// inserting bubbles.
//
// Optional feature macro: DECODE_STAGE_M_EXT_EN. When it is defined, OP and
// OP-32 with funct7=0x01 decode as M extension operations. When it is
// undefined, that encoding is illegal.
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   flush                  synchronous kill of OR and SK
//   in_valid/in_ready      fetch handshake (in_ready = !skid_valid)
//   in_pc, in_instr        PC and raw 32-bit instruction from fetch
//   out_valid/out_ready    execute handshake
//   out_pc                 PC carried through
//   opcode, rd, rs1, rs2,
//   funct3, funct7         raw instruction fields
//   imm                    sign-extended immediate (0 for R-type)
//   alu_op                 ALU operation code
//   reg_write_enable, mem_read, mem_write, branch, jump, is_word, illegal
//                          control flags; all flags are cleared when illegal=1
module decode_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic            reg_write_enable,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            is_word,
  output logic            illegal
);

  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
`ifdef DECODE_STAGE_M_EXT_EN
  localparam logic [3:0] ALU_MUL   = 4'd12;
  localparam logic [3:0] ALU_MULH  = 4'd13;
  localparam logic [3:0] ALU_DIV   = 4'd14;
  localparam logic [3:0] ALU_REM   = 4'd15;
`endif

  // Base integer ALU mapping. alt is instr[30]; SUB applies only to register ops.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    logic [3:0] r;
    case (f3)
      3'd0:    r = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

`ifdef DECODE_STAGE_M_EXT_EN
  // M extension mapping; execute uses funct3 for signedness.
  function automatic logic [3:0] m_alu_of(input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'd0:       r = ALU_MUL;
      3'd1, 3'd2,
      3'd3:       r = ALU_MULH;
      3'd4, 3'd5: r = ALU_DIV;
      default:    r = ALU_REM;
    endcase
    return r;
  endfunction
`endif

  // Buffer state
  logic            skid_valid;
  logic [XLEN-1:0] sk_pc;
  logic [31:0]     sk_instr;

  logic out_valid_d, skid_valid_d;
  logic or_load, sk_load, sel_sk;
  logic or_drain, in_fire;

  assign in_ready = !skid_valid;

  // Next-state for OR/SK occupancy; flush overrides all movement
  always_comb begin
    out_valid_d  = out_valid;
    skid_valid_d = skid_valid;
    or_load      = 1'b0;
    sk_load      = 1'b0;
    sel_sk       = 1'b0;
    or_drain     = !out_valid || out_ready;
    in_fire      = in_valid && !skid_valid;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (or_drain) begin
      if (skid_valid) begin
        // in_ready is low while SK is full, so no new input arrives here
        or_load      = 1'b1;
        sel_sk       = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        or_load     = in_fire;
        out_valid_d = in_fire;
      end
    end else if (in_fire) begin
      sk_load      = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Decode source: the skid entry has priority because it is older
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  assign dec_instr = sel_sk ? sk_instr : in_instr;
  assign dec_pc    = sel_sk ? sk_pc    : in_pc;

  logic [6:0]      d_opc, d_f7;
  logic [2:0]      d_f3;
  logic [4:0]      d_rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            f7_ok, sh_ok;

  assign d_opc = dec_instr[6:0];
  assign d_f3  = dec_instr[14:12];
  assign d_f7  = dec_instr[31:25];
  assign d_rd  = dec_instr[11:7];

  assign imm_i = XLEN'($signed(dec_instr[31:20]));
  assign imm_s = XLEN'($signed({dec_instr[31:25], dec_instr[11:7]}));
  assign imm_b = XLEN'($signed({dec_instr[31], dec_instr[7], dec_instr[30:25],
                                dec_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({dec_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({dec_instr[31], dec_instr[19:12], dec_instr[20],
                                dec_instr[30:21], 1'b0}));

  assign f7_ok = (d_f7 == 7'h00) || (d_f7 == 7'h20);
  // RV64 immediate shifts use a 6-bit shamt, so instr[25] belongs to shamt
  assign sh_ok = (XLEN == 64) ? ((dec_instr[31:26] == 6'h00) || (dec_instr[31:26] == 6'h10))
                              : f7_ok;

  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_alu;
  logic            d_rwe, d_mr, d_mw, d_br, d_jp, d_word, d_ill;

  // Combinational decode of the selected instruction
  always_comb begin
    d_imm  = '0;
    d_alu  = ALU_ADD;
    d_rwe  = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_jp   = 1'b0;
    d_word = 1'b0;
    d_ill  = 1'b0;
    case (d_opc)
      OPC_LUI: begin
        d_imm = imm_u;
        d_alu = ALU_PASSB;
        d_rwe = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u;
        d_rwe = 1'b1;
      end
      OPC_JAL: begin
        d_imm = imm_j;
        d_jp  = 1'b1;
        d_rwe = 1'b1;
      end
      OPC_JALR: begin
        d_imm = imm_i;
        d_jp  = 1'b1;
        d_rwe = 1'b1;
      end
      OPC_BRANCH: begin
        d_imm = imm_b;
        d_alu = ALU_SUB;
        d_br  = 1'b1;
      end
      OPC_LOAD: begin
        d_imm = imm_i;
        d_mr  = 1'b1;
        d_rwe = 1'b1;
        // LD and LWU exist only on RV64
        if ((XLEN == 32) && ((d_f3 == 3'd3) || (d_f3 == 3'd6))) d_ill = 1'b1;
      end
      OPC_STORE: begin
        d_imm = imm_s;
        d_mw  = 1'b1;
        if ((XLEN == 32) && (d_f3 == 3'd3)) d_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        d_imm = imm_i;
        d_alu = alu_of(d_f3, dec_instr[30], 1'b0);
        d_rwe = 1'b1;
        if (((d_f3 == 3'd1) || (d_f3 == 3'd5)) && !sh_ok) d_ill = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        d_rwe  = 1'b1;
        d_word = (d_opc == OPC_OP_32);
`ifdef DECODE_STAGE_M_EXT_EN
        if (d_f7 == 7'h01) begin
          d_alu = m_alu_of(d_f3);
        end else begin
          d_alu = alu_of(d_f3, dec_instr[30], 1'b1);
          d_ill = !f7_ok;
        end
`else
        d_alu = alu_of(d_f3, dec_instr[30], 1'b1);
        d_ill = !f7_ok;
`endif
        if ((XLEN == 32) && (d_opc == OPC_OP_32)) d_ill = 1'b1;
      end
      OPC_OP_IMM_32: begin
        d_imm  = imm_i;
        d_alu  = alu_of(d_f3, dec_instr[30], 1'b0);
        d_rwe  = 1'b1;
        d_word = 1'b1;
        // Word shifts have a 5-bit shamt, so the full funct7 is checked
        if (((d_f3 == 3'd1) || (d_f3 == 3'd5)) && !f7_ok) d_ill = 1'b1;
        if (XLEN == 32) d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (dec_instr[1:0] != 2'b11) d_ill = 1'b1;
    if (d_rd == 5'd0) d_rwe = 1'b0;
    if (d_ill) begin
      d_rwe  = 1'b0;
      d_mr   = 1'b0;
      d_mw   = 1'b0;
      d_br   = 1'b0;
      d_jp   = 1'b0;
      d_word = 1'b0;
    end
  end

  // Output register; payload only changes on load, so it holds while stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      opcode           <= '0;
      rd               <= '0;
      rs1              <= '0;
      rs2              <= '0;
      funct3           <= '0;
      funct7           <= '0;
      imm              <= '0;
      alu_op           <= '0;
      reg_write_enable <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      branch           <= 1'b0;
      jump             <= 1'b0;
      is_word          <= 1'b0;
      illegal          <= 1'b0;
    end else begin
      out_valid <= out_valid_d;
      if (or_load) begin
        out_pc           <= dec_pc;
        opcode           <= d_opc;
        rd               <= d_rd;
        rs1              <= dec_instr[19:15];
        rs2              <= dec_instr[24:20];
        funct3           <= d_f3;
        funct7           <= d_f7;
        imm              <= d_imm;
        alu_op           <= d_alu;
        reg_write_enable <= d_rwe;
        mem_read         <= d_mr;
        mem_write        <= d_mw;
        branch           <= d_br;
        jump             <= d_jp;
        is_word          <= d_word;
        illegal          <= d_ill;
      end
    end
  end

  // Skid entry stores the raw instruction; it is decoded when moved to OR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_valid <= 1'b0;
      sk_pc      <= '0;
      sk_instr   <= '0;
    end else begin
      skid_valid <= skid_valid_d;
      if (sk_load) begin
        sk_pc    <= in_pc;
        sk_instr <= in_instr;
      end
    end
  end

endmodule
